// File: rtl/inst_loader.sv
// inst_loader: stages a host program, bursts it to a PE instruction port,
// then watches the PE's replay-valid for completion or timeout.
module inst_loader #(
  parameter int unsigned INST_WIDTH    = 16,
  parameter int unsigned IM_ADDR_WIDTH = 4,
  parameter int unsigned GAP           = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_we,
  input  logic [IM_ADDR_WIDTH-1:0]   prog_addr,
  input  logic [INST_WIDTH-1:0]      prog_data,
  input  logic                       start,
  input  logic [IM_ADDR_WIDTH:0]     num_inst,
  input  logic                       exec_v,
  output logic                       inst_v,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [IM_ADDR_WIDTH+1:0]   exec_cnt
);

  localparam int unsigned DEPTH = 1 << IM_ADDR_WIDTH;
  localparam int unsigned LEN_W = IM_ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = IM_ADDR_WIDTH + 2;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 2);
  localparam int unsigned GAP_W = $clog2(GAP + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [INST_WIDTH-1:0] mem [DEPTH];

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [TO_W-1:0]  to_q;
  logic [GAP_W-1:0] gap_q;
  logic             seen_q;
  logic [CNT_W-1:0] cnt_q;

  logic             len_ok_c;
  logic             last_c;
  logic             fall_c;
  logic             expire_c;
  logic             gap_last_c;
  logic [CNT_W-1:0] cnt_inc_c;

  logic             rd_en_c;
  logic             done_d;
  logic             err_d;
  logic             busy_d;

  // Shared decode terms used by next-state, outputs and datapath
  always_comb begin
    len_ok_c   = (num_inst != '0) && (num_inst <= LEN_W'(DEPTH));
    last_c     = (idx_q == (len_q - LEN_W'(1)));
    fall_c     = seen_q && !exec_v;
    expire_c   = !seen_q && !exec_v && (to_q == TO_W'(TIMEOUT - 1));
    gap_last_c = (gap_q == GAP_W'(GAP - 1));
    cnt_inc_c  = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_W'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; falling edge of exec_v is only armed once it was seen in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && len_ok_c) state_d = S_SEND;
      S_SEND: if (last_c) state_d = S_WAIT;
      S_WAIT: begin
        if (fall_c)        state_d = (GAP == 0) ? S_IDLE : S_GAP;
        else if (expire_c) state_d = S_IDLE;
      end
      S_GAP:  if (gap_last_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered status outputs
  always_comb begin
    rd_en_c = (state_q == S_SEND);
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: err_d  = start && !len_ok_c;
      S_WAIT: begin
        done_d = fall_c && (GAP == 0);
        err_d  = expire_c;
      end
      S_GAP:  done_d = gap_last_c;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Staging buffer write port, open only while idle
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) mem[prog_addr] <= prog_data;
  end

  // Run datapath: burst index, timeout, gap and saturating exec counters
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      idx_q  <= '0;
      to_q   <= '0;
      gap_q  <= '0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && len_ok_c) begin
            len_q  <= num_inst;
            idx_q  <= '0;
            to_q   <= '0;
            gap_q  <= '0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
          end
        end
        S_SEND: begin
          idx_q <= idx_q + LEN_W'(1);
          if (exec_v) cnt_q <= cnt_inc_c;
        end
        S_WAIT: begin
          if (!seen_q) to_q <= to_q + TO_W'(1);
          if (exec_v) begin
            seen_q <= 1'b1;
            cnt_q  <= cnt_inc_c;
          end
        end
        S_GAP: gap_q <= gap_q + GAP_W'(1);
        default: ;
      endcase
    end
  end

  // Registered outputs; inst_out doubles as the buffer's read register and holds between bursts
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_v   <= 1'b0;
      inst_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      exec_cnt <= '0;
    end else begin
      inst_v <= rd_en_c;
      if (rd_en_c) inst_out <= mem[idx_q[IM_ADDR_WIDTH-1:0]];
      busy <= busy_d;
      done <= done_d;
      err  <= err_d;
      if (done_d) exec_cnt <= cnt_q;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboarded bench for inst_loader: stimulus plans each run from the
// behavioural rules and queues expected output events; a monitor checks them.
module tb_inst_loader;

  localparam int unsigned IW      = 16;
  localparam int unsigned AW      = 4;
  localparam int          DEPTH   = 16;
  localparam int          GAP     = 2;
  localparam int          TIMEOUT = 1024;
  localparam int          CNT_MAX = 63;
  localparam int          MAXC    = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          start;
  logic [AW:0]   num_inst;
  logic          exec_v;
  logic          inst_v;
  logic [IW-1:0] inst_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW+1:0] exec_cnt;

  inst_loader #(
    .INST_WIDTH(IW), .IM_ADDR_WIDTH(AW), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .num_inst(num_inst),
    .exec_v(exec_v), .inst_v(inst_v), .inst_out(inst_out), .busy(busy),
    .done(done), .err(err), .exec_cnt(exec_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 beat, 1 done, 2 err
    logic [IW-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            next_free = 0;
  bit            mon_en = 1'b0;
  bit            exec_sched [MAXC];
  bit            busy_exp   [MAXC];
  bit            rst_mark   [MAXC];
  logic [IW-1:0] buf_m      [DEPTH];
  logic [IW-1:0] hold_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int c, input int k, input logic [IW-1:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int k, input logic [IW-1:0] act);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d data=%0h", k, cyc, act);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc || e.data !== act) begin
      errors++;
      $display("FAIL event: got kind=%0d cyc=%0d data=%0h, expected kind=%0d cyc=%0d data=%0h",
               k, cyc, act, e.kind, e.cyc, e.data);
    end
    if (k == 0) hold_exp = e.data;
  endtask

  // Monitor: pops expected events when the DUT presents them; checks busy and hold value each cycle
  always @(negedge clk) begin
    if (mon_en && cyc < MAXC) begin
      if (rst_mark[cyc]) hold_exp = '0;
      if (inst_v === 1'b1) check_evt(0, inst_out);
      if (done === 1'b1)   check_evt(1, IW'(exec_cnt));
      if (err === 1'b1)    check_evt(2, '0);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_event kind=%0d expected cycle %0d, now cycle %0d",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      checks++;
      if (busy !== busy_exp[cyc]) begin
        errors++;
        $display("FAIL busy cycle %0d: got %b expected %b", cyc, busy, busy_exp[cyc]);
      end
      if (inst_v !== 1'b1) begin
        checks++;
        if (inst_out !== hold_exp) begin
          errors++;
          $display("FAIL inst_out_hold cycle %0d: got %0h expected %0h", cyc, inst_out, hold_exp);
        end
      end
      checks++;
      if (done === 1'b1 && err === 1'b1) begin
        errors++;
        $display("FAIL done_err_overlap cycle %0d: got both 1 expected not both", cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exec_v = (cyc < MAXC) ? exec_sched[cyc] : 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < next_free) tick();
  endtask

  task automatic write_word(input int a, input logic [IW-1:0] v);
    wait_idle();
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = v;
    buf_m[a] = v;
    tick();
    prog_we = 1'b0;
  endtask

  // mode: 0 normal, 1 exec_v never rises, 2 write+restart attempt during the burst
  task automatic run(input int n, input int p, input int d, input int l, input int mode);
    int t, e, f, endc, cnt;
    wait_idle();
    repeat ($urandom_range(0, 2)) begin
      exec_sched[cyc + 1] = 1'($urandom_range(0, 1));
      tick();
    end
    t = cyc;
    start = 1'b1; num_inst = (AW+1)'(n);
    if (n >= 1 && n <= DEPTH) begin
      e = t + n + 1;
      for (int k = 0; k < n; k++) push_ev(t + 2 + k, 0, buf_m[k]);
      for (int i = 1; i <= p; i++) exec_sched[t + i] = 1'b1;
      if (mode == 1) begin
        endc = e + TIMEOUT;
        push_ev(endc, 2, '0);
      end else begin
        f = e + d;
        for (int i = 0; i < l; i++) exec_sched[f + i] = 1'b1;
        endc = f + l + GAP + 1;
        cnt = (p + l > CNT_MAX) ? CNT_MAX : p + l;
        push_ev(endc, 1, IW'(cnt));
      end
      for (int c = t + 1; c < endc; c++) busy_exp[c] = 1'b1;
      next_free = endc;
    end else begin
      push_ev(t + 1, 2, '0);
      next_free = t + 1;
    end
    tick();
    start = 1'b0;
    if (mode == 2) begin
      tick();
      prog_we = 1'b1; prog_addr = AW'(1); prog_data = IW'(16'h00AA);
      start = 1'b1; num_inst = (AW+1)'(3);
      tick();
      prog_we = 1'b0; start = 1'b0;
    end
  endtask

  // Reset pulse three beats into a ten-word burst
  task automatic run_reset();
    int t, r;
    wait_idle();
    t = cyc;
    start = 1'b1; num_inst = (AW+1)'(10);
    r = t + 5;
    for (int k = 0; k < 4; k++) push_ev(t + 2 + k, 0, buf_m[k]);
    for (int c = t + 1; c <= r; c++) busy_exp[c] = 1'b1;
    rst_mark[r + 1] = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < r) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    next_free = r + 1;
    @(negedge clk);
    checks++;
    if (exec_cnt !== '0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got exec_cnt=%0d done=%b err=%b expected 0 0 0", exec_cnt, done, err);
    end
  endtask

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, p;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; num_inst = '0; exec_v = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_v !== 1'b0 || inst_out !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || exec_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b out=%0h busy=%b done=%b err=%b cnt=%0d expected all 0",
               inst_v, inst_out, busy, done, err, exec_cnt);
    end

    // Basic three-word program; exec_v high 4 cycles, 10 cycles after the last beat
    write_word(0, IW'(16'h0011));
    write_word(1, IW'(16'h0022));
    write_word(2, IW'(16'h0033));
    run(3, 0, 10, 4, 0);

    // Illegal lengths
    run(0, 0, 0, 0, 0);
    run(DEPTH + 1, 0, 0, 0, 0);

    // Full-depth burst
    for (int i = 0; i < DEPTH; i++) write_word(i, IW'(i));
    run(DEPTH, 0, 3, 2, 0);

    // Timeout, then a new start must be accepted
    run(2, 0, 0, 0, 1);
    run(4, 2, 1, 3, 0);

    // Buffer write and restart attempt mid-burst are ignored
    run(5, 0, 4, 3, 2);
    run(2, 0, 2, 1, 0);

    // Reset mid-burst, then a clean run from address 0
    run_reset();
    run(3, 0, 1, 2, 0);

    // exec_cnt saturation
    run(1, 1, 2, 70, 0);

    // Randomised runs
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(0, 3)) write_word($urandom_range(0, DEPTH - 1), IW'($urandom));
      if ($urandom_range(0, 7) == 0)
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 2 * DEPTH - 1);
      else
        n = $urandom_range(1, DEPTH);
      p = (n > 0) ? $urandom_range(0, n) : 0;
      run(n, p, $urandom_range(0, 12), $urandom_range(1, 8), 0);
    end

    wait_idle();
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Host-side transmitter that feeds the PE instruction memory (`inst_mem`).
- Host writes a program into a local staging buffer, then issues `start`. The block streams the program as one contiguous `inst_v`/`inst_out` burst into the PE.
- It then monitors the PE's replay-valid (`exec_v`) to detect completion, enforces an idle gap, and reports `done` or `err`.
- Sits between the host/config interface and each PE's instruction port.

Parameters:
- GAP, 2, idle cycles after `exec_v` falls before the next start is accepted.
- TIMEOUT, 1024, maximum cycles in WAIT_EXEC waiting for `exec_v` to rise.
- Widths come from `parameters.vh`: `INST_WIDTH`, `IM_ADDR_WIDTH`. DEPTH = 2**`IM_ADDR_WIDTH`.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- prog_we  in  1  staging-buffer write strobe
- prog_addr  in  IM_ADDR_WIDTH  staging write address
- prog_data  in  INST_WIDTH  staging write data
- start  in  1  single-cycle request to transmit the program
- num_inst  in  IM_ADDR_WIDTH+1  burst length; sampled with `start`
- exec_v  in  1  PE instruction-memory output valid (execution indicator)
- inst_v  out  1  instruction valid to PE
- inst_out  out  INST_WIDTH  instruction word to PE
- busy  out  1  transfer/execution in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse (bad length or timeout)
- exec_cnt  out  IM_ADDR_WIDTH+2  number of `exec_v`-high cycles in the last run; valid while `done`=1

Behaviour:
- Reset: one clock, synchronous, active-high. State goes to IDLE. `inst_v`, `inst_out`, `busy`, `done`, `err`, `exec_cnt` all reset to 0. Staging buffer is not cleared. Reset mid-run aborts from the next edge: no `done`, no `err`.
- Staging buffer: DEPTH x INST_WIDTH, synchronous read, 1-cycle latency. `prog_we` is honoured only in IDLE; it is ignored while `busy`=1.
- FSM states: IDLE, SEND, WAIT_EXEC, GAP.
- IDLE:
  - `start`=1 with 1 <= `num_inst` <= DEPTH: latch `num_inst`, clear the internal exec counter, go to SEND. `busy`=1 from the next cycle.
  - `start` with `num_inst`=0 or `num_inst` > DEPTH: stay in IDLE, `err`=1 for one cycle.
- SEND:
  - Read address runs 0..`num_inst`-1, one per cycle.
  - If `start` is accepted at cycle T, `inst_v`=1 in cycles T+2 .. T+1+`num_inst`, contiguous with no bubbles.
  - `inst_out` carries `buf[k]` in burst cycle k. `inst_out` holds its last value when `inst_v`=0.
  - After the last word, go to WAIT_EXEC.
- WAIT_EXEC:
  - A timeout counter starts at entry.
  - Count every cycle with `exec_v`=1.
  - Once `exec_v` has been seen high and then samples low, go to GAP.
  - If `exec_v` never rises within TIMEOUT cycles: go to IDLE, `err`=1 for one cycle, `busy`=0, no `done`.
- GAP: hold for GAP cycles, then go to IDLE with `done`=1 for one cycle. `exec_cnt` is updated in the same cycle, `busy` drops in the same cycle.
- `start` while `busy`=1 is ignored with no `err`.
- `exec_v` pulses in IDLE are ignored.
- `exec_v` high during SEND is counted; the falling-edge detect is armed only in WAIT_EXEC.
- `exec_cnt` saturates at its maximum value; it holds until the next completed run.
- `done` and `err` are never asserted in the same cycle.

Test Plan:
- Load `buf[0..2]`=0x11,0x22,0x33; start with `num_inst`=3 at T. Stub asserts `exec_v` for 4 cycles starting 10 cycles after the burst ends. Required: `inst_v`=1 at T+2..T+4 with data 0x11,0x22,0x33; `done` pulses GAP(2) cycles after `exec_v` falls; `exec_cnt`=4; `busy` low the same cycle as `done`.
- `num_inst`=0, then `num_inst`=DEPTH+1 -> `err` pulses one cycle each; `inst_v` stays 0; `busy` stays 0.
- `num_inst`=DEPTH with full buffer (`buf[i]`=i) -> DEPTH contiguous `inst_v` cycles, data 0..DEPTH-1, no bubble; address does not wrap early.
- Stub never asserts `exec_v` -> `err` exactly TIMEOUT cycles after WAIT_EXEC entry; `done` never asserted; a new start is then accepted.
- `prog_we` to addr 1 (value 0xAA) during SEND, plus a second `start` mid-run -> buffer unchanged (next run sends the original word); second start ignored; exactly one `done`.
- Assert `rst` for one cycle in the middle of the burst -> `inst_v`=0 from the next cycle; all outputs 0; no `done`/`err`; a fresh start afterwards transmits correctly from address 0.
